// File: rtl/titan_pkg.sv
// Shared definitions for the titan execution unit: datapath widths, ALU opcodes
// and the requester port id type.
package titan_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 4;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'd0;
  localparam alu_op_t ALU_SUB  = 4'd1;
  localparam alu_op_t ALU_AND  = 4'd2;
  localparam alu_op_t ALU_OR   = 4'd3;
  localparam alu_op_t ALU_XOR  = 4'd4;
  localparam alu_op_t ALU_SLL  = 4'd5;
  localparam alu_op_t ALU_SRA  = 4'd6;
  localparam alu_op_t ALU_SRL  = 4'd7;
  localparam alu_op_t ALU_SLT  = 4'd8;
  localparam alu_op_t ALU_SLTU = 4'd9;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/titan_exu.sv
// Combinational integer ALU. Unassigned opcodes (10-15) yield zero.
module titan_exu
  import titan_pkg::*;
(
  input  alu_op_t         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;

  always_comb begin
    shamt    = b_i[4:0];
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/titan_exu_arbiter.sv
// Two-port arbiter sharing one titan_exu through a single issue register and
// per-port response buffers. Define TITAN_EXU_ARB_RR_EN for round-robin grants.
module titan_exu_arbiter
  import titan_pkg::*;
#(
  parameter int unsigned INIT_PTR = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [ALU_OP_W-1:0] req0_op_i,
  input  logic [XLEN-1:0]     req0_a_i,
  input  logic [XLEN-1:0]     req0_b_i,
  output logic                rsp0_valid_o,
  input  logic                rsp0_ready_i,
  output logic [XLEN-1:0]     rsp0_result_o,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [ALU_OP_W-1:0] req1_op_i,
  input  logic [XLEN-1:0]     req1_a_i,
  input  logic [XLEN-1:0]     req1_b_i,
  output logic                rsp1_valid_o,
  input  logic                rsp1_ready_i,
  output logic [XLEN-1:0]     rsp1_result_o
);

  logic [1:0]      req_valid, req_ready, rsp_ready;
  alu_op_t         req_op [2];
  logic [XLEN-1:0] req_a  [2];
  logic [XLEN-1:0] req_b  [2];

  logic            s1_valid_q;
  port_id_t        s1_owner_q;
  alu_op_t         s1_op_q;
  logic [XLEN-1:0] s1_a_q, s1_b_q;

  logic [1:0]      r_valid_q, r_load;
  logic [XLEN-1:0] r_result_q [2];

  logic [XLEN-1:0] alu_result;
  logic            s1_adv, s1_load;
  port_id_t        prio, winner;

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};
  assign req_op[0] = req0_op_i;
  assign req_op[1] = req1_op_i;
  assign req_a[0]  = req0_a_i;
  assign req_a[1]  = req1_a_i;
  assign req_b[0]  = req0_b_i;
  assign req_b[1]  = req1_b_i;

  // S1 drains into its owner's buffer if that buffer is empty or emptying now.
  assign s1_adv  = s1_valid_q & (~r_valid_q[s1_owner_q] | rsp_ready[s1_owner_q]);
  assign s1_load = ~s1_valid_q | s1_adv;

`ifdef TITAN_EXU_ARB_RR_EN
  port_id_t ptr_q;

  assign prio = ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= INIT_PTR[0];
    end else if (|(req_valid & req_ready)) begin
      ptr_q <= ~winner;
    end
  end
`else
  logic unused_init_ptr;

  assign prio            = PORT0;
  assign unused_init_ptr = (INIT_PTR != 0);
`endif

  always_comb begin
    winner = prio;
    if (req_valid[0] && !req_valid[1]) begin
      winner = PORT0;
    end else if (req_valid[1] && !req_valid[0]) begin
      winner = PORT1;
    end
    req_ready = '0;
    if (!rst_i && s1_load && (|req_valid)) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_owner_q <= PORT0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (s1_load) begin
      s1_valid_q <= |req_ready;
      if (|req_ready) begin
        s1_owner_q <= winner;
        s1_op_q    <= req_op[winner];
        s1_a_q     <= req_a[winner];
        s1_b_q     <= req_b[winner];
      end
    end
  end

  titan_exu u_exu (
    .op_i     (s1_op_q),
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .result_o (alu_result)
  );

  always_comb begin
    r_load             = '0;
    r_load[s1_owner_q] = s1_adv;
  end

  for (genvar g = 0; g < 2; g++) begin : g_rsp
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_valid_q[g]  <= 1'b0;
        r_result_q[g] <= '0;
      end else if (r_load[g]) begin
        r_valid_q[g]  <= 1'b1;
        r_result_q[g] <= alu_result;
      end else if (rsp_ready[g]) begin
        r_valid_q[g]  <= 1'b0;
      end
    end
  end

  assign req0_ready_o  = req_ready[0];
  assign req1_ready_o  = req_ready[1];
  assign rsp0_valid_o  = r_valid_q[0];
  assign rsp1_valid_o  = r_valid_q[1];
  assign rsp0_result_o = r_result_q[0];
  assign rsp1_result_o = r_result_q[1];

endmodule

// File: tb/tb_titan_exu_arbiter.sv
// Directed bench for titan_exu_arbiter; inputs driven and outputs sampled on the
// falling edge so every check sees settled registered state.
module tb_titan_exu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_result, rsp1_result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  titan_exu_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req0_valid_i  (req0_valid),
    .req0_ready_o  (req0_ready),
    .req0_op_i     (req0_op),
    .req0_a_i      (req0_a),
    .req0_b_i      (req0_b),
    .rsp0_valid_o  (rsp0_valid),
    .rsp0_ready_i  (rsp0_ready),
    .rsp0_result_o (rsp0_result),
    .req1_valid_i  (req1_valid),
    .req1_ready_o  (req1_ready),
    .req1_op_i     (req1_op),
    .req1_a_i      (req1_a),
    .req1_b_i      (req1_b),
    .rsp1_valid_o  (rsp1_valid),
    .rsp1_ready_i  (rsp1_ready),
    .rsp1_result_o (rsp1_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // One isolated op: accept, S1 cycle, response visible, then drained.
  task automatic run_op(input string tag, input int p, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    drive(p, 1'b1, op, a, b);
    #1 check({tag, "_ready"}, (p == 0) ? req0_ready : req1_ready, 1);
    @(negedge clk);
    idle();
    check({tag, "_s1_no_rsp"}, {rsp1_valid, rsp0_valid}, 0);
    @(negedge clk);
    check({tag, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, (p == 0) ? 2'b01 : 2'b10);
    check({tag, "_result"}, (p == 0) ? rsp0_result : rsp1_result, exp);
    @(negedge clk);
    check({tag, "_drained"}, {rsp1_valid, rsp0_valid}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] tp_exp [8];
  logic [1:0]  rr_exp;
  int          accepts;
  int          j;

  initial begin
    // Reset state, with requests present to show readies are held low.
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'd1, 32'd1);
    drive(1, 1'b1, 4'd0, 32'd1, 32'd1);
    #1 check("rst_ready", {req1_ready, req0_ready}, 0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("rst_result0", rsp0_result, 0);
    check("rst_result1", rsp1_result, 0);

    run_op("add", 0, 4'd0, 32'd5, 32'd7, 32'h0000000C);
    run_op("sra", 1, 4'd6, 32'h80000000, 32'd4, 32'hF8000000);
    run_op("slt", 0, 4'd8, 32'hFFFFFFFF, 32'd1, 32'd1);
    run_op("sltu", 1, 4'd9, 32'hFFFFFFFF, 32'd1, 32'd0);
    run_op("op12", 0, 4'd12, 32'h12345678, 32'h9ABCDEF0, 32'd0);
    run_op("sub", 1, 4'd1, 32'd3, 32'd5, 32'hFFFFFFFE);
    run_op("sll", 0, 4'd5, 32'h00000003, 32'h00000024, 32'h00000030);

    // Contention from a fresh pointer.
    do_reset();
    drive(0, 1'b1, 4'd0, 32'd1, 32'd0);
    drive(1, 1'b1, 4'd0, 32'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef TITAN_EXU_ARB_RR_EN
      rr_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      rr_exp = 2'b01;
`endif
      #1 check($sformatf("contend_grant%0d", i), {req1_ready, req0_ready}, rr_exp);
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);

    // Backpressure: R0 full and a port-0 op stuck in S1 blocks both ports.
    do_reset();
    rsp0_ready = 1'b0;
    drive(0, 1'b1, 4'd0, 32'd1, 32'd1);
    #1 check("bp_acc_a", req0_ready, 1);
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'd2, 32'd2);
    #1 check("bp_acc_b", req0_ready, 1);
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'd3, 32'd3);
    drive(1, 1'b1, 4'd0, 32'd9, 32'd9);
    #1 check("bp_stall_ready", {req1_ready, req0_ready}, 0);
    check("bp_hold_result", rsp0_result, 32'd2);
    @(negedge clk);
    check("bp_stall_ready2", {req1_ready, req0_ready}, 0);
    check("bp_stable_valid", rsp0_valid, 1);
    check("bp_stable_result", rsp0_result, 32'd2);
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    #1 check("bp_refill_ready", req0_ready, 1);
    @(negedge clk);
    idle();
    check("bp_second_valid", rsp0_valid, 1);
    check("bp_second_result", rsp0_result, 32'd4);
    @(negedge clk);
    check("bp_third_valid", rsp0_valid, 1);
    check("bp_third_result", rsp0_result, 32'd6);
    check("bp_port1_quiet", rsp1_valid, 0);
    @(negedge clk);
    check("bp_drained", {rsp1_valid, rsp0_valid}, 0);

    // Throughput: 8 alternating ops, one accept per cycle, responses routed.
    accepts = 0;
    for (int i = 0; i < 8; i++) tp_exp[i] = 32'(i * 16 + 1) + 32'(i);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      j = k - 2;
      if (j >= 0 && j < 8) begin
        check($sformatf("tp_valid%0d", j), {rsp1_valid, rsp0_valid},
              (j % 2 == 0) ? 2'b01 : 2'b10);
        check($sformatf("tp_result%0d", j), (j % 2 == 0) ? rsp0_result : rsp1_result,
              tp_exp[j]);
      end
      idle();
      if (k < 8) begin
        drive(k % 2, 1'b1, 4'd0, 32'(k * 16 + 1), 32'(k));
        #1 if ((k % 2 == 0) ? req0_ready : req1_ready) accepts++;
      end
    end
    check("tp_accepts", accepts, 8);

    // Reset one cycle after accepting an op.
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'd5, 32'd5);
    #1 check("mid_acc", req0_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1'b1, 4'd0, 32'd1, 32'd1);
    #1 check("mid_rst_ready", {req1_ready, req0_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_no_rsp", {rsp1_valid, rsp0_valid}, 0);
    check("mid_result0", rsp0_result, 0);
    check("mid_result1", rsp1_result, 0);
    drive(0, 1'b1, 4'd0, 32'd5, 32'd5);
    drive(1, 1'b1, 4'd0, 32'd8, 32'd8);
    #1 check("mid_ptr_init", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk);
    idle();
    check("mid_s1_no_rsp", {rsp1_valid, rsp0_valid}, 0);
    @(negedge clk);
    check("mid_post_valid", {rsp1_valid, rsp0_valid}, 2'b01);
    check("mid_post_result", rsp0_result, 32'd10);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
